spc7110_bank_mapper: RTL and testbench
======================================

// Module: spc7110_bank_mapper
// PURPOSE
// - Registered, parametrised successor to the combinational SPC7110 address map: owns the DROM bank registers
//   ($4831+n) and the SRAM-enable register ($4830) internally, not as inputs.
// - Translates each SNES bus cycle to a masked PSRAM address through a 2-stage pipeline.
// - Sits between the SNES bus sampler and the PSRAM arbiter; NUM_WIN bank windows replace the fixed D/E/F trio.
// PARAMETERS
// - NUM_WIN      3         number of bank-switchable 1 MiB DROM windows (1..3)
// - BANK_W       3         bank register width; physical unit = bank + DROM_BASE
// - DROM_BASE    1         units of 1 MiB reserved below DROM (PROM size)
// - WIN_NIB      4'hD      SNES_ADDR[23:20] of window 0; window n at WIN_NIB+n
// - PROM_NIB     4'hC      SNES_ADDR[23:20] of direct PROM bank group
// - REG_BASE     16'h4831  address of bank register 0 (banks 00-3F/80-BF)
// PORTS
// - CLK            in   1   system clock
// - RST_N          in   1   synchronous reset, active low
// - SNES_ADDR      in   24  sampled SNES address
// - SNES_DATA      in   8   sampled SNES write data
// - ADDR_STB       in   1   one-cycle pulse: SNES_ADDR valid, start translation
// - WR_STB         in   1   one-cycle pulse: SNES write completes (data valid)
// - ROM_MASK       in   24  ROM size mask
// - SAVERAM_MASK   in   24  SRAM size mask; bit0=0 means no SRAM
// - ROM_ADDR       out  24  translated PSRAM address
// - ROM_HIT        out  1   translated cycle targets PSRAM
// - IS_SAVERAM     out  1   translated cycle targets SRAM
// - ADDR_VALID     out  1   one-cycle pulse: ROM_ADDR/ROM_HIT/IS_SAVERAM valid
// - BANK_CHANGED   out  1   one-cycle pulse: a bank register value changed
// - SRAM_EN        out  1   $4830 bit7
// BEHAVIOUR
// - Reset (RST_N=0 at edge): bank[n]=n, SRAM_EN=0, pipeline flushed; all outputs 0, ADDR_VALID=0.
// - Register write: WR_STB & !SNES_ADDR[22] & SNES_ADDR[15:0]==REG_BASE+n (n<NUM_WIN):
//   bank[n]<=SNES_DATA[BANK_W-1:0] next edge. ==REG_BASE-1: SRAM_EN<=SNES_DATA[7]. Other $48xx ignored.
// - BANK_CHANGED pulses 1 cycle after a bank write whose value differs; same-value write: no pulse.
// - Pipeline: stage1 on ADDR_STB latches addr + decode class; stage2 computes masked address.
//   ADDR_VALID asserts exactly 2 cycles after ADDR_STB; outputs hold until the next ADDR_VALID.
// - Back-to-back ADDR_STB every cycle: fully pipelined, one result per cycle, in order.
// - Decode (nib=SNES_ADDR[23:20]):
//   SAVERAM: SAVERAM_MASK[0] & SRAM_EN & !A[22] & A[21] & !A[15] & A[14:13]==2'b11
//            -> 24'hE00000 + ({A[20:16],A[12:0]} & SAVERAM_MASK).
//   PROM: nib==PROM_NIB -> {3'b0,A[20:0]} & ROM_MASK.
//   WINDOW n: nib==WIN_NIB+n, n<NUM_WIN
//             -> {bank[n]+DROM_BASE, A[19:0]} & ROM_MASK; sum truncated to 24 bits.
//   nib in window range but n>=NUM_WIN: ROM_HIT=0, ROM_ADDR=0.
//   Other ROM (A[22] | A[15]): {3'b0,A[20:0]} & ROM_MASK. Otherwise ROM_HIT=0.
// - Bank write and ADDR_STB same edge: stage1 samples the PRE-write bank value;
//   translation uses the bank captured in stage1, not the live register.
// - Bank overflow: bank+DROM_BASE beyond ROM_MASK wraps via mask; no error flag.
// - Reset mid-pipeline: in-flight results discarded, no ADDR_VALID issued for them.
// STRUCTURE
// - Package spc7110_pkg: decode-class enum {CLS_NONE,CLS_SRAM,CLS_PROM,CLS_DROM,CLS_ROM},
//   register address constants, SRAM base 24'hE00000.
// - Sub-module spc7110_bank_regs: register file + SRAM_EN + change detect.
//   Top holds decode and the 2-stage pipeline.
// TESTING
// - Reset, ADDR_STB @D01234 -> ADDR_VALID at +2, ROM_ADDR=24'h101234 (bank0=0), ROM_HIT=1.
// - WR $4832=05, then ADDR_STB @E0ABCD, ROM_MASK=FFFFFF
//   -> BANK_CHANGED pulse; ROM_ADDR=24'h60ABCD.
// - WR $4831=07 same edge as ADDR_STB @D00000 -> old result 24'h100000; next strobe 24'h800000.
// - @306000, SRAM_EN=0 -> IS_SAVERAM=0; WR $4830=80 -> IS_SAVERAM=1,
//   ROM_ADDR=24'hE00000 (SAVERAM_MASK=001FFF).
// - NUM_WIN=2: @F00000 -> ROM_HIT=0; stream of 8 consecutive ADDR_STB -> 8 in-order ADDR_VALID.
// - RST_N low one cycle after ADDR_STB -> no ADDR_VALID; banks back to 0,1,2.

Source files
------------

// File: rtl/spc7110_pkg.sv
// spc7110_pkg: shared decode classes and register/address constants for the SPC7110 mapper
package spc7110_pkg;
    typedef enum logic [2:0] {CLS_NONE, CLS_SRAM, CLS_PROM, CLS_DROM, CLS_ROM} cls_t;
    localparam logic [15:0] REG_SRAM_EN = 16'h4830;
    localparam logic [15:0] REG_BANK0   = 16'h4831;
    localparam logic [23:0] SRAM_BASE   = 24'hE00000;
    localparam int          MAX_WIN     = 3;
endpackage

// File: rtl/spc7110_bank_regs.sv
// spc7110_bank_regs: DROM bank registers, SRAM enable and bank-change pulse
module spc7110_bank_regs
    import spc7110_pkg::*;
#(
    parameter int          NUM_WIN  = 3,
    parameter int          BANK_W   = 3,
    parameter logic [15:0] REG_BASE = REG_BANK0
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic [23:0]                     SNES_ADDR,
    input  logic [7:0]                      SNES_DATA,
    input  logic                            WR_STB,
    output logic [NUM_WIN-1:0][BANK_W-1:0]  BANK,
    output logic                            SRAM_EN,
    output logic                            BANK_CHANGED
);
    logic               wr_ok;
    logic               sram_hit;
    logic               changed;
    logic [NUM_WIN-1:0] hit;
    logic               unused_bits;

    assign unused_bits = ^{SNES_DATA, SNES_ADDR[23], SNES_ADDR[21:16]};

    // Address match for each register; a change is any hit whose new value differs
    always_comb begin
        wr_ok    = WR_STB && !SNES_ADDR[22];
        sram_hit = wr_ok && SNES_ADDR[15:0] == REG_BASE - 16'd1;
        hit      = '0;
        changed  = 1'b0;
        for (int n = 0; n < NUM_WIN; n++) begin
            hit[n]  = wr_ok && SNES_ADDR[15:0] == REG_BASE + 16'(n);
            changed = changed | (hit[n] && BANK[n] != SNES_DATA[BANK_W-1:0]);
        end
    end

    // Register file update; banks reset to their own window index
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int n = 0; n < NUM_WIN; n++) BANK[n] <= BANK_W'(n);
            SRAM_EN      <= 1'b0;
            BANK_CHANGED <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_WIN; n++) if (hit[n]) BANK[n] <= SNES_DATA[BANK_W-1:0];
            if (sram_hit) SRAM_EN <= SNES_DATA[7];
            BANK_CHANGED <= changed;
        end
    end
endmodule

// File: rtl/spc7110_bank_mapper.sv
// spc7110_bank_mapper: two-stage SNES-to-PSRAM address translator with internal bank registers
module spc7110_bank_mapper
    import spc7110_pkg::*;
#(
    parameter int          NUM_WIN   = 3,
    parameter int          BANK_W    = 3,
    parameter int          DROM_BASE = 1,
    parameter logic [3:0]  WIN_NIB   = 4'hD,
    parameter logic [3:0]  PROM_NIB  = 4'hC,
    parameter logic [15:0] REG_BASE  = 16'h4831
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [23:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA,
    input  logic        ADDR_STB,
    input  logic        WR_STB,
    input  logic [23:0] ROM_MASK,
    input  logic [23:0] SAVERAM_MASK,
    output logic [23:0] ROM_ADDR,
    output logic        ROM_HIT,
    output logic        IS_SAVERAM,
    output logic        ADDR_VALID,
    output logic        BANK_CHANGED,
    output logic        SRAM_EN
);
    logic [NUM_WIN-1:0][BANK_W-1:0] bank;
    logic [3:0]        nib;
    logic [3:0]        win_off;
    logic [BANK_W-1:0] win_bank;
    cls_t              cls;
    logic              s1_v;
    logic [20:0]       s1_addr;
    cls_t              s1_cls;
    logic [BANK_W-1:0] s1_bank;
    logic [3:0]        unit;
    logic [23:0]       xlat;

    spc7110_bank_regs #(
        .NUM_WIN (NUM_WIN),
        .BANK_W  (BANK_W),
        .REG_BASE(REG_BASE)
    ) u_regs (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SNES_ADDR   (SNES_ADDR),
        .SNES_DATA   (SNES_DATA),
        .WR_STB      (WR_STB),
        .BANK        (bank),
        .SRAM_EN     (SRAM_EN),
        .BANK_CHANGED(BANK_CHANGED)
    );

    // Classify the incoming address and pick the bank of the addressed window
    always_comb begin
        nib      = SNES_ADDR[23:20];
        win_off  = nib - WIN_NIB;
        win_bank = '0;
        for (int n = 0; n < NUM_WIN; n++) if (win_off == 4'(n)) win_bank = bank[n];
        cls = (SAVERAM_MASK[0] && SRAM_EN && !SNES_ADDR[22] && SNES_ADDR[21] && !SNES_ADDR[15] && SNES_ADDR[14:13] == 2'b11) ? CLS_SRAM :
              (nib == PROM_NIB)                 ? CLS_PROM :
              (win_off < 4'(NUM_WIN))           ? CLS_DROM :
              (win_off < 4'(MAX_WIN))           ? CLS_NONE :
              (SNES_ADDR[22] || SNES_ADDR[15])  ? CLS_ROM  : CLS_NONE;
    end

    // Stage 1: capture address, class and the pre-write bank value on each strobe
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_v    <= 1'b0;
            s1_addr <= '0;
            s1_cls  <= CLS_NONE;
            s1_bank <= '0;
        end else begin
            s1_v <= ADDR_STB;
            if (ADDR_STB) begin
                s1_addr <= SNES_ADDR[20:0];
                s1_cls  <= cls;
                s1_bank <= win_bank;
            end
        end
    end

    // Masked PSRAM address for the captured class; bank overflow wraps through the mask
    always_comb begin
        unit = 4'(s1_bank) + 4'(DROM_BASE);
        xlat = (s1_cls == CLS_SRAM) ? SRAM_BASE + ({6'b0, s1_addr[20:16], s1_addr[12:0]} & SAVERAM_MASK) :
               (s1_cls == CLS_DROM) ? {unit, s1_addr[19:0]} & ROM_MASK :
               (s1_cls == CLS_PROM || s1_cls == CLS_ROM) ? {3'b0, s1_addr} & ROM_MASK : '0;
    end

    // Stage 2: publish the result and hold it until the next valid pulse
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ROM_ADDR   <= '0;
            ROM_HIT    <= 1'b0;
            IS_SAVERAM <= 1'b0;
            ADDR_VALID <= 1'b0;
        end else begin
            ADDR_VALID <= s1_v;
            if (s1_v) begin
                ROM_ADDR   <= xlat;
                ROM_HIT    <= s1_cls != CLS_NONE;
                IS_SAVERAM <= s1_cls == CLS_SRAM;
            end
        end
    end
endmodule

// File: tb/tb_spc7110_bank_mapper.sv
// tb_spc7110_bank_mapper: directed checks of decode, bank registers and pipeline timing
module tb_spc7110_bank_mapper;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [23:0] SNES_ADDR = '0;
    logic [7:0]  SNES_DATA = '0;
    logic        ADDR_STB = 1'b0;
    logic        WR_STB = 1'b0;
    logic [23:0] ROM_MASK = 24'hFFFFFF;
    logic [23:0] SAVERAM_MASK = 24'h001FFF;

    logic [23:0] rom_addr, w2_rom_addr, lo_rom_addr;
    logic        rom_hit, w2_rom_hit, lo_rom_hit;
    logic        is_saveram, w2_is_saveram, lo_is_saveram;
    logic        addr_valid, w2_addr_valid, lo_addr_valid;
    logic        bank_changed, w2_bank_changed, lo_bank_changed;
    logic        sram_en, w2_sram_en, lo_sram_en;

    int n_tests = 0;
    int n_fail = 0;

    spc7110_bank_mapper u_dut (
        .CLK(CLK), .RST_N(RST_N), .SNES_ADDR(SNES_ADDR), .SNES_DATA(SNES_DATA),
        .ADDR_STB(ADDR_STB), .WR_STB(WR_STB), .ROM_MASK(ROM_MASK), .SAVERAM_MASK(SAVERAM_MASK),
        .ROM_ADDR(rom_addr), .ROM_HIT(rom_hit), .IS_SAVERAM(is_saveram),
        .ADDR_VALID(addr_valid), .BANK_CHANGED(bank_changed), .SRAM_EN(sram_en)
    );

    spc7110_bank_mapper #(.NUM_WIN(2)) u_w2 (
        .CLK(CLK), .RST_N(RST_N), .SNES_ADDR(SNES_ADDR), .SNES_DATA(SNES_DATA),
        .ADDR_STB(ADDR_STB), .WR_STB(WR_STB), .ROM_MASK(ROM_MASK), .SAVERAM_MASK(SAVERAM_MASK),
        .ROM_ADDR(w2_rom_addr), .ROM_HIT(w2_rom_hit), .IS_SAVERAM(w2_is_saveram),
        .ADDR_VALID(w2_addr_valid), .BANK_CHANGED(w2_bank_changed), .SRAM_EN(w2_sram_en)
    );

    // Windows placed at nibble 0 so one bus address can both hit a bank register and a window
    spc7110_bank_mapper #(.WIN_NIB(4'h0)) u_lo (
        .CLK(CLK), .RST_N(RST_N), .SNES_ADDR(SNES_ADDR), .SNES_DATA(SNES_DATA),
        .ADDR_STB(ADDR_STB), .WR_STB(WR_STB), .ROM_MASK(ROM_MASK), .SAVERAM_MASK(SAVERAM_MASK),
        .ROM_ADDR(lo_rom_addr), .ROM_HIT(lo_rom_hit), .IS_SAVERAM(lo_is_saveram),
        .ADDR_VALID(lo_addr_valid), .BANK_CHANGED(lo_bank_changed), .SRAM_EN(lo_sram_en)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        SNES_ADDR = a;
        SNES_DATA = d;
        WR_STB = 1'b1;
        tick;
        WR_STB = 1'b0;
    endtask

    task automatic strobe(input logic [23:0] a);
        SNES_ADDR = a;
        ADDR_STB = 1'b1;
        tick;
        ADDR_STB = 1'b0;
        chk("valid_at_plus1", addr_valid, 0);
        tick;
    endtask

    task automatic xlat(input string tag, input logic [23:0] a, input logic [23:0] ea, input logic eh, input logic es);
        strobe(a);
        chk({tag, "_valid"}, addr_valid, 1);
        chk({tag, "_addr"}, rom_addr, ea);
        chk({tag, "_hit"}, rom_hit, eh);
        chk({tag, "_sram"}, is_saveram, es);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int late;
        tick;
        tick;
        chk("rst_addr", rom_addr, 0);
        chk("rst_hit", rom_hit, 0);
        chk("rst_sram", is_saveram, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_changed", bank_changed, 0);
        chk("rst_sram_en", sram_en, 0);
        RST_N = 1'b1;
        tick;

        xlat("win0_reset", 24'hD01234, 24'h101234, 1, 0);

        wr(24'h004832, 8'h05);
        chk("bank1_changed", bank_changed, 1);
        tick;
        chk("bank1_changed_pulse", bank_changed, 0);
        xlat("win1_bank5", 24'hE0ABCD, 24'h60ABCD, 1, 0);
        wr(24'h004832, 8'h05);
        chk("same_value_no_pulse", bank_changed, 0);

        SNES_ADDR = 24'h004831;
        SNES_DATA = 8'h07;
        WR_STB = 1'b1;
        ADDR_STB = 1'b1;
        tick;
        WR_STB = 1'b0;
        ADDR_STB = 1'b0;
        chk("bank0_changed", bank_changed, 1);
        tick;
        chk("same_edge_valid", lo_addr_valid, 1);
        chk("same_edge_old_bank", lo_rom_addr, 24'h104831);
        xlat("win0_bank7", 24'hD00000, 24'h800000, 1, 0);

        ROM_MASK = 24'h7FFFFF;
        xlat("bank_overflow_wrap", 24'hD01234, 24'h001234, 1, 0);
        ROM_MASK = 24'hFFFFFF;

        xlat("sram_disabled", 24'h306000, 24'h000000, 0, 0);
        wr(24'h004830, 8'h80);
        chk("sram_en_set", sram_en, 1);
        xlat("sram_base", 24'h306000, 24'hE00000, 1, 1);
        xlat("sram_masked", 24'h316ABC, 24'hE00ABC, 1, 1);
        SAVERAM_MASK = 24'h001FFE;
        xlat("sram_absent", 24'h306000, 24'h000000, 0, 0);
        SAVERAM_MASK = 24'h001FFF;

        xlat("prom", 24'hC12345, 24'h012345, 1, 0);
        xlat("other_rom", 24'h008000, 24'h008000, 1, 0);
        xlat("win2", 24'hF00000, 24'h300000, 1, 0);
        chk("w2_win2_valid", w2_addr_valid, 1);
        chk("w2_win2_hit", w2_rom_hit, 0);
        chk("w2_win2_addr", w2_rom_addr, 0);

        seen = 0;
        for (int c = 0; c < 10; c++) begin
            ADDR_STB = (c < 8);
            SNES_ADDR = 24'hC00000 | 24'(c);
            tick;
            if (addr_valid) begin
                chk("stream_order", rom_addr, 24'(seen));
                seen++;
            end
        end
        ADDR_STB = 1'b0;
        chk("stream_count", 24'(seen), 8);

        SNES_ADDR = 24'hD00000;
        ADDR_STB = 1'b1;
        tick;
        ADDR_STB = 1'b0;
        RST_N = 1'b0;
        tick;
        RST_N = 1'b1;
        late = 0;
        for (int c = 0; c < 3; c++) begin
            if (addr_valid) late++;
            tick;
        end
        chk("flush_no_valid", 24'(late), 0);
        chk("flush_sram_en", sram_en, 0);
        xlat("rst_bank0", 24'hD00000, 24'h100000, 1, 0);
        xlat("rst_bank1", 24'hE00000, 24'h200000, 1, 0);
        xlat("rst_bank2", 24'hF00000, 24'h300000, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
